full_adder: RTL and testbench

// - Registered full adder: computes a + b + cin; sum and carry-out appear one clock later.
// - Built as a ripple chain of 1-bit full-adder cells. WIDTH=1 gives the classic single-bit adder.
// - Arithmetic leaf used by datapath blocks that need a carry-in/carry-out adder with a

---
 rtl/full_adder_cell.sv | 13 +
 rtl/full_adder.sv | 73 +++++++
 tb/tb_full_adder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell; the ripple element of full_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with carry-in/carry-out, signed overflow flag and an
// optional single output register stage.
module full_adder #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Overflow is the disagreement between carry into and out of the MSB.
  assign cout_c = carry[WIDTH];
  assign ovf_c  = carry[WIDTH-1] ^ carry[WIDTH];

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    always_comb begin
      sum_d  = sum_c;
      cout_d = cout_c;
      ovf_d  = ovf_c;
      if (rst) begin
        sum_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
  end else begin : g_comb
    // clk and rst are intentionally left without a load in this mode.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sum  = sum_c;
    assign cout = cout_c;
    assign ovf  = ovf_c;
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: directed corner cases plus randomized traffic checked
// against an arithmetic reference model.
module tb_full_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rst1, a1, b1, cin1;
  logic       sum1, cout1, ovf1;
  logic       rst8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8;
  logic       rst4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       cout4, ovf4;

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_c4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned total for sum/cout, signed total range for ovf.
  function automatic logic [9:0] ref_add(input int w, input int a, input int b, input int ci);
    int total, sa, sb, st;
    logic [9:0] r;
    total = a + b + ci;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    st = sa + sb + ci;
    r = '0;
    r[7:0] = 8'(total % (1 << w));
    r[8]   = (total >= (1 << w));
    r[9]   = (st > (1 << (w - 1)) - 1) || (st < -(1 << (w - 1)));
    return r;
  endfunction

  task automatic drive1(input logic a, input logic b, input logic ci);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic expect8(input string tag, input logic [7:0] s, input logic co, input logic ov);
    check({tag, " sum"},  32'(sum8),  32'(s));
    check({tag, " cout"}, 32'(cout8), 32'(co));
    check({tag, " ovf"},  32'(ovf8),  32'(ov));
  endtask

  logic [2:0] sweep_in  [8] = '{3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111, 3'b000};
  logic [1:0] sweep_exp [8] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};

  initial begin
    logic [9:0] m;
    logic [2:0] v;
    logic [1:0] e;
    logic [7:0] ra, rb;
    logic       rc;

    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    rst8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    rst4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset held for two edges with all-ones inputs.
    repeat (2) @(posedge clk);
    #1;
    check("w1 rst sum",  32'(sum1),  32'd0);
    check("w1 rst cout", 32'(cout1), 32'd0);
    check("w1 rst ovf",  32'(ovf1),  32'd0);
    expect8("w8 rst", 8'h00, 1'b0, 1'b0);

    @(negedge clk);
    rst1 = 1'b0; rst8 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = sweep_in[i];
      e = sweep_exp[i];
      drive1(v[2], v[1], v[0]);
      check($sformatf("w1 sweep%0d sum", i),  32'(sum1),  32'(e[1]));
      check($sformatf("w1 sweep%0d cout", i), 32'(cout1), 32'(e[0]));
      check($sformatf("w1 sweep%0d ovf", i),  32'(ovf1),  32'(v[0] ^ e[0]));
    end

    drive8(8'hFF, 8'h01, 1'b0); expect8("w8 ff+01",    8'h00, 1'b1, 1'b0);
    drive8(8'h7F, 8'h00, 1'b1); expect8("w8 7f+00+1",  8'h80, 1'b0, 1'b1);
    drive8(8'h80, 8'h80, 1'b0); expect8("w8 80+80",    8'h00, 1'b1, 1'b1);
    drive8(8'hAA, 8'h55, 1'b1); expect8("w8 aa+55+1",  8'h00, 1'b1, 1'b0);

    // Reset in the middle of a stream, then recovery from held inputs.
    drive8(8'h12, 8'h34, 1'b0); expect8("w8 pre-rst", 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    expect8("w8 mid-rst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst8 = 1'b0;
    @(posedge clk);
    #1;
    expect8("w8 post-rst", 8'h46, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      drive8(ra, rb, rc);
      m = ref_add(8, int'(ra), int'(rb), int'(rc));
      expect8($sformatf("w8 rnd%0d", i), m[7:0], m[8], m[9]);
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(1));
      rb = 8'($urandom_range(1));
      rc = 1'($urandom_range(1));
      drive1(ra[0], rb[0], rc);
      m = ref_add(1, int'(ra), int'(rb), int'(rc));
      check("w1 rnd sum",  32'(sum1),  32'(m[0]));
      check("w1 rnd cout", 32'(cout1), 32'(m[8]));
      check("w1 rnd ovf",  32'(ovf1),  32'(m[9]));
    end

    // Combinational instance: same-step response, clock and reset irrelevant.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    #1;
    check("c4 sum",  32'(sum4),  32'h0);
    check("c4 cout", 32'(cout4), 32'd1);
    check("c4 ovf",  32'(ovf4),  32'd0);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    check("c4 rst sum",  32'(sum4),  32'h0);
    check("c4 rst cout", 32'(cout4), 32'd1);
    rst4 = 1'b0;

    for (int i = 0; i < 60; i++) begin
      a4 = 4'($urandom_range(15));
      b4 = 4'($urandom_range(15));
      cin4 = 1'($urandom_range(1));
      rst4 = 1'($urandom_range(1));
      #3;
      m = ref_add(4, int'(a4), int'(b4), int'(cin4));
      check("c4 rnd sum",  32'(sum4),  32'(m[3:0]));
      check("c4 rnd cout", 32'(cout4), 32'(m[8]));
      check("c4 rnd ovf",  32'(ovf4),  32'(m[9]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
